// File: rtl/cnt_timer_if.sv
// cnt_timer_if: control and status bundle for cnt_timer (psc present with CNT_TIMER_PRESCALER_EN)
interface cnt_timer_if #(parameter int width = 32, parameter int pwidth = 8);
  logic en;
  logic restart;
  logic oneshot;
  logic down;
  logic [width-1:0] top;
  logic [width-1:0] cnt;
  logic i;
  logic running;
`ifdef CNT_TIMER_PRESCALER_EN
  logic [pwidth-1:0] psc;
  modport master (output en, restart, oneshot, down, top, psc, input cnt, i, running);
  modport slave (input en, restart, oneshot, down, top, psc, output cnt, i, running);
`else
  modport master (output en, restart, oneshot, down, top, input cnt, i, running);
  modport slave (input en, restart, oneshot, down, top, output cnt, i, running);
`endif
endinterface

// File: rtl/cnt_timer.sv
// cnt_timer: programmable up/down periodic or one-shot timer, optional prescaler via CNT_TIMER_PRESCALER_EN
module cnt_timer #(parameter int width = 32, parameter int pwidth = 8) (
  input logic clk,
  input logic rst,
  cnt_timer_if.slave t
);
  logic [width-1:0] c, last, start;
  logic p_i, run, term, done, tick;
  if (width < 1 || pwidth < 1) begin : g_chk
    $error("cnt_timer: width and pwidth must be positive");
  end
  assign last = t.top - width'(1);
  assign start = t.down ? last : '0;
  assign term = t.down ? (c == '0) : (c >= last);
  assign tick = t.en & run & done;
`ifdef CNT_TIMER_PRESCALER_EN
  logic [pwidth-1:0] p;
  assign done = p >= t.psc;
  // prescaler counts enabled cycles while armed, wrapping once it reaches psc
  always_ff @(posedge clk) begin
    if (rst || t.restart) p <= '0;
    else if (t.en && run) p <= done ? '0 : p + pwidth'(1);
  end
`else
  assign done = 1'b1;
`endif
  // counter, terminal pulse and one-shot arming
  always_ff @(posedge clk) begin
    if (rst) begin
      c <= '0;
      p_i <= 1'b0;
      run <= 1'b1;
    end else if (t.restart) begin
      c <= start;
      p_i <= 1'b0;
      run <= 1'b1;
    end else begin
      p_i <= tick & term;
      if (tick) c <= term ? start : (t.down ? c - width'(1) : c + width'(1));
      run <= ~t.oneshot | (run & ~(tick & term));
    end
  end
  assign t.cnt = c;
  assign t.i = p_i;
  assign t.running = run;
endmodule
